// File: rtl/instruction_assembler_if.sv
// Request/result bundle for the instruction assembler.
// The slave side is the encoder; the master side drives requests and consumes results.
interface instruction_assembler_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_sel;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] immediate;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic        error;
  logic [15:0] encode_count;
  logic [7:0]  error_count;

  modport slave (
    input  in_valid, imm_sel, opcode, rd, rs1, rs2, funct3, funct7, immediate, out_ready,
    output in_ready, out_valid, instruction, error, encode_count, error_count
  );

  modport master (
    output in_valid, imm_sel, opcode, rd, rs1, rs2, funct3, funct7, immediate, out_ready,
    input  in_ready, out_valid, instruction, error, encode_count, error_count
  );
endinterface

// File: rtl/instruction_assembler.sv
// Two-stage RISC-V instruction word assembler.
// S1 captures the request and its immediate range check; S2 holds the packed word.
// Unencodable requests complete normally but emit a NOP with error set.
module instruction_assembler (
  input  logic                    clk_i,
  input  logic                    reset_i,
  instruction_assembler_if.slave  bus
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        s1_valid_q;
  logic        s1_err_q;
  logic [2:0]  s1_sel_q;
  logic [6:0]  s1_opcode_q;
  logic [4:0]  s1_rd_q;
  logic [4:0]  s1_rs1_q;
  logic [4:0]  s1_rs2_q;
  logic [2:0]  s1_funct3_q;
  logic [6:0]  s1_funct7_q;
  logic [31:0] s1_imm_q;

  logic        out_valid_q;
  logic        error_q;
  logic [31:0] instruction_q;
  logic [15:0] encode_count_q;
  logic [7:0]  error_count_q;

  logic        advance;
  logic        in_ready;
  logic        range_err;
  logic [31:0] packed_word;
  logic [31:0] imm;

  // S2 moves whenever its content is absent or being consumed; S1 refills behind it.
  assign advance  = !out_valid_q || bus.out_ready;
  assign in_ready = !s1_valid_q || advance;
  assign imm      = bus.immediate;

  // Immediate range check on the incoming request.
  always_comb begin
    range_err = 1'b0;
    case (bus.imm_sel)
      3'b000, 3'b001: range_err = !((&imm[31:11]) || !(|imm[31:11]));
      3'b010:         range_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      3'b011:         range_err = |imm[11:0];
      3'b100:         range_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      3'b101:         range_err = 1'b0;
      default:        range_err = 1'b1;
    endcase
  end

  // Field packing of the S1 request; any error collapses the word to a NOP.
  always_comb begin
    packed_word = Nop;
    case (s1_sel_q)
      3'b000: packed_word = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      3'b001: packed_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_imm_q[4:0],
                             s1_opcode_q};
      3'b010: packed_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                             s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
      3'b011: packed_word = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
      3'b100: packed_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                             s1_rd_q, s1_opcode_q};
      3'b101: packed_word = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      default: packed_word = Nop;
    endcase
    if (s1_err_q) packed_word = Nop;
  end

  // Stage 1: capture request fields and range-check result on accept.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_sel_q    <= 3'b000;
      s1_opcode_q <= 7'd0;
      s1_rd_q     <= 5'd0;
      s1_rs1_q    <= 5'd0;
      s1_rs2_q    <= 5'd0;
      s1_funct3_q <= 3'd0;
      s1_funct7_q <= 7'd0;
      s1_imm_q    <= 32'd0;
    end else if (in_ready) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_err_q    <= range_err;
        s1_sel_q    <= bus.imm_sel;
        s1_opcode_q <= bus.opcode;
        s1_rd_q     <= bus.rd;
        s1_rs1_q    <= bus.rs1;
        s1_rs2_q    <= bus.rs2;
        s1_funct3_q <= bus.funct3;
        s1_funct7_q <= bus.funct7;
        s1_imm_q    <= bus.immediate;
      end
    end
  end

  // Stage 2: register the packed word; held while the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_valid_q   <= 1'b0;
      error_q       <= 1'b0;
      instruction_q <= 32'd0;
    end else if (advance) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        instruction_q <= packed_word;
        error_q       <= s1_err_q;
      end
    end
  end

  // Output handshake counters: total wraps, error count saturates.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      encode_count_q <= 16'd0;
      error_count_q  <= 8'd0;
    end else if (out_valid_q && bus.out_ready) begin
      encode_count_q <= encode_count_q + 16'd1;
      if (error_q && (error_count_q != 8'hFF)) error_count_q <= error_count_q + 8'd1;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.instruction  = instruction_q;
  assign bus.error        = error_q;
  assign bus.encode_count = encode_count_q;
  assign bus.error_count  = error_count_q;

endmodule

// File: tb/tb_instruction_assembler.sv
// Self-checking bench for instruction_assembler: directed table, stall, reset and random traffic.
module tb_instruction_assembler;

  typedef struct {
    logic [2:0]  sel;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  logic clk;
  logic reset;
  instruction_assembler_if bus ();

  instruction_assembler dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_fail;
  logic [32:0] sb_q[$];
  logic [15:0] m_enc;
  logic [7:0]  m_err;
  logic        last_stall;
  logic [31:0] last_instr;
  logic        last_err;
  vec_t        tbl[14];
  vec_t        idle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoder written from the format rules using signed ranges.
  function automatic logic [32:0] model(input vec_t v);
    longint s;
    logic [31:0] i;
    logic [31:0] w;
    logic e;
    i = v.imm;
    s = longint'($signed(v.imm));
    w = 32'h13;
    e = 1'b0;
    case (v.sel)
      3'd0: begin e = (s < -2048 || s > 2047); w = {i[11:0], v.rs1, v.f3, v.rd, v.op}; end
      3'd1: begin
        e = (s < -2048 || s > 2047);
        w = {i[11:5], v.rs2, v.rs1, v.f3, i[4:0], v.op};
      end
      3'd2: begin
        e = (s < -4096 || s > 4095 || (s % 2) != 0);
        w = {i[12], i[10:5], v.rs2, v.rs1, v.f3, i[4:1], i[11], v.op};
      end
      3'd3: begin e = (i % 4096) != 0; w = {i[31:12], v.rd, v.op}; end
      3'd4: begin
        e = (s < -1048576 || s > 1048575 || (s % 2) != 0);
        w = {i[20], i[10:1], i[11], i[19:12], v.rd, v.op};
      end
      3'd5: begin e = 1'b0; w = {v.f7, v.rs2, v.rs1, v.f3, v.rd, v.op}; end
      default: e = 1'b1;
    endcase
    if (e) w = 32'h13;
    return {e, w};
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.sel = 3'($urandom_range(0, 7));
    v.op  = 7'($urandom);
    v.rd  = 5'($urandom);
    v.rs1 = 5'($urandom);
    v.rs2 = 5'($urandom);
    v.f3  = 3'($urandom);
    v.f7  = 7'($urandom);
    case ($urandom_range(0, 3))
      0: v.imm = $urandom;
      1: v.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: v.imm = $urandom & 32'hFFFF_F000;
      default: v.imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
    endcase
    v.exp_instr = 32'h0;
    v.exp_err   = 1'b0;
    return v;
  endfunction

  // One cycle: check held outputs, drive at negedge, score the handshakes of the coming edge.
  task automatic step(input logic iv, input vec_t v, input logic ordy, output logic acc);
    logic [32:0] e;
    @(negedge clk);
    if (last_stall) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_instr", bus.instruction, last_instr);
      check("hold_err", 32'(bus.error), 32'(last_err));
    end
    check("encode_count", 32'(bus.encode_count), 32'(m_enc));
    check("error_count", 32'(bus.error_count), 32'(m_err));
    if (bus.out_valid && sb_q.size() == 0) check("spurious_out_valid", 32'd1, 32'd0);
    bus.in_valid  = iv;
    bus.imm_sel   = v.sel;
    bus.opcode    = v.op;
    bus.rd        = v.rd;
    bus.rs1       = v.rs1;
    bus.rs2       = v.rs2;
    bus.funct3    = v.f3;
    bus.funct7    = v.f7;
    bus.immediate = v.imm;
    bus.out_ready = ordy;
    #1;
    acc = iv && bus.in_ready;
    if (bus.out_valid && ordy && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("result_instr", bus.instruction, e[31:0]);
      check("result_err", 32'(bus.error), 32'(e[32]));
      m_enc = m_enc + 16'd1;
      if (e[32] && m_err != 8'hFF) m_err = m_err + 8'd1;
    end
    if (acc) sb_q.push_back(model(v));
    last_stall = bus.out_valid && !ordy;
    last_instr = bus.instruction;
    last_err   = bus.error;
  endtask

  task automatic do_reset();
    vec_t v;
    v = tbl[0];
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid  = 1'b1;
    bus.imm_sel   = v.sel;
    bus.immediate = v.imm;
    bus.out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    sb_q.delete();
    m_enc = 16'd0;
    m_err = 8'd0;
    last_stall = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    check("rst_instr", bus.instruction, 32'd0);
    check("rst_encode_count", 32'(bus.encode_count), 32'd0);
    check("rst_error_count", 32'(bus.error_count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  function automatic vec_t mk(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [31:0] ei, input logic ee);
    vec_t v;
    v.sel = sel; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp_instr = ei; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    logic acc;
    logic pending;
    n_cmp = 0;
    n_fail = 0;
    m_enc = 16'd0;
    m_err = 8'd0;
    last_stall = 1'b0;
    last_instr = 32'd0;
    last_err = 1'b0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.imm_sel = 3'd0;
    bus.opcode = 7'd0;
    bus.rd = 5'd0;
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd0;
    bus.funct3 = 3'd0;
    bus.funct7 = 7'd0;
    bus.immediate = 32'd0;
    idle = mk(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'd0, 1'b0);

    tbl[0]  = mk(3'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd1871, 32'h74F10093, 1'b0);
    tbl[1]  = mk(3'd1, 7'h23, 5'd0, 5'd2, 5'd1, 3'd2, 7'd0, 32'd60, 32'h02112E23, 1'b0);
    tbl[2]  = mk(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd1200, 32'h4A208863, 1'b0);
    tbl[3]  = mk(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd1201, 32'h00000013, 1'b1);
    tbl[4]  = mk(3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 32'h00000013, 1'b1);
    tbl[5]  = mk(3'd5, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hFFFFFFFF, 32'h403100B3, 1'b0);
    tbl[6]  = mk(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
    tbl[7]  = mk(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h00000013, 1'b1);
    tbl[8]  = mk(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h001000EF, 1'b0);
    tbl[9]  = mk(3'd4, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFE, 32'hFFFFF06F, 1'b0);
    tbl[10] = mk(3'd4, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, 32'h00000013, 1'b1);
    tbl[11] = mk(3'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h80000013, 1'b0);
    tbl[12] = mk(3'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h00000013, 1'b1);
    tbl[13] = mk(3'd1, 7'h23, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFE000FA3, 1'b0);

    do_reset();

    // Directed table: each request alone, result exactly two edges after accept.
    foreach (tbl[k]) begin
      step(1'b1, tbl[k], 1'b1, acc);
      check("tbl_accept", 32'(acc), 32'd1);
      step(1'b0, idle, 1'b1, acc);
      check("tbl_lat1_valid", 32'(bus.out_valid), 32'd0);
      step(1'b0, idle, 1'b1, acc);
      check("tbl_lat2_valid", 32'(bus.out_valid), 32'd1);
      check("tbl_instr", bus.instruction, tbl[k].exp_instr);
      check("tbl_err", 32'(bus.error), 32'(tbl[k].exp_err));
    end

    // Two error requests from reset: both counters reach 2.
    do_reset();
    for (int k = 3; k <= 4; k++) begin
      step(1'b1, tbl[k], 1'b1, acc);
      step(1'b0, idle, 1'b1, acc);
      step(1'b0, idle, 1'b1, acc);
    end
    step(1'b0, idle, 1'b1, acc);
    check("err_seq_encode_count", 32'(bus.encode_count), 32'd2);
    check("err_seq_error_count", 32'(bus.error_count), 32'd2);

    // Back-to-back with consumer stalled: pipeline fills, ready drops, order preserved.
    do_reset();
    step(1'b1, tbl[0], 1'b0, acc);
    step(1'b1, tbl[1], 1'b0, acc);
    check("bp_second_accept", 32'(acc), 32'd1);
    pending = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, tbl[2], 1'b0, acc);
      check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      check("bp_held_instr", bus.instruction, tbl[0].exp_instr);
    end
    for (int c = 0; c < 8; c++) begin
      step(pending, tbl[2], 1'b1, acc);
      if (acc) pending = 1'b0;
    end
    check("bp_third_accepted", 32'(pending), 32'd0);
    check("bp_encode_count", 32'(bus.encode_count), 32'd3);
    check("bp_drained", sb_q.size(), 32'd0);

    // Reset with two requests in flight: nothing stale may appear afterwards.
    step(1'b1, tbl[5], 1'b0, acc);
    step(1'b1, tbl[6], 1'b0, acc);
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step(1'b0, idle, 1'b1, acc);
      check("post_rst_no_valid", 32'(bus.out_valid), 32'd0);
    end

    // Random traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      step(1'($urandom_range(0, 9) < 7), rand_vec(), 1'($urandom_range(0, 9) < 6), acc);
    end
    for (int c = 0; c < 6; c++) step(1'b0, idle, 1'b1, acc);
    check("rand_drained", sb_q.size(), 32'd0);

    // Error counter saturation.
    do_reset();
    for (int c = 0; c < 270; c++) step(1'b1, tbl[4], 1'b1, acc);
    for (int c = 0; c < 4; c++) step(1'b0, idle, 1'b1, acc);
    check("err_count_saturated", 32'(bus.error_count), 32'hFF);
    check("enc_count_270", 32'(bus.encode_count), 32'd270);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_assembler.md
INSTRUCTION_ASSEMBLER -- requirements
Module: instruction_assembler

Interface
REQ-001 SHALL have ports, clock and reset first: CLK in 1, clock, all state updates on rising edge; RESET in 1, synchronous active-high reset.
REQ-002 SHALL have input-side ports: IN_VALID in 1, request valid; IN_READY out 1, request accepted when IN_VALID&&IN_READY at a CLK edge.
REQ-003 SHALL have request fields: IMM_SEL in 3, format select (000 I, 001 S, 010 B, 011 U, 100 J, 101 R, 110/111 illegal); OPCODE in 7; RD, RS1, RS2 in 5 each; FUNCT3 in 3; FUNCT7 in 7; IMMEDIATE in 32, signed byte-offset/value.
REQ-004 SHALL have output-side ports: OUT_VALID out 1; OUT_READY in 1, result consumed when OUT_VALID&&OUT_READY at a CLK edge.
REQ-005 SHALL have result ports: INSTRUCTION out 32, encoded word; ERROR out 1, request not encodable.
REQ-006 SHALL have status ports: ENCODE_COUNT out 16, output handshakes; ERROR_COUNT out 8, output handshakes with ERROR=1.

Function
REQ-007 SHALL be a 2-stage pipeline: S1 registers request and computes range check; S2 registers packed INSTRUCTION/ERROR.
REQ-008 SHALL, with no stall, present OUT_VALID=1 and the result after the 2nd CLK edge following acceptance; throughput 1 request/cycle.
REQ-009 SHALL advance the pipeline when !OUT_VALID || OUT_READY; IN_READY = !S1_valid || advance (combinational).
REQ-010 SHALL hold INSTRUCTION, ERROR, OUT_VALID stable while OUT_VALID && !OUT_READY; no request dropped or duplicated.
REQ-011 SHALL encode I: [31:20]=imm[11:0], [19:15]=RS1, [14:12]=FUNCT3, [11:7]=RD, [6:0]=OPCODE.
REQ-012 SHALL encode S: [31:25]=imm[11:5], [24:20]=RS2, [19:15]=RS1, [14:12]=FUNCT3, [11:7]=imm[4:0], [6:0]=OPCODE.
REQ-013 SHALL encode B: [31]=imm[12], [30:25]=imm[10:5], RS2/RS1/FUNCT3 as S, [11:8]=imm[4:1], [7]=imm[11], [6:0]=OPCODE.
REQ-014 SHALL encode U: [31:12]=imm[31:12], [11:7]=RD, [6:0]=OPCODE.
REQ-015 SHALL encode J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], [11:7]=RD, [6:0]=OPCODE.
REQ-016 SHALL encode R: [31:25]=FUNCT7, RS2, RS1, FUNCT3, RD, OPCODE; IMMEDIATE ignored, never errors.
REQ-017 SHALL flag ERROR: I/S if IMMEDIATE[31:11] not all equal; B if [31:12] not all equal or [0]=1; U if [11:0]!=0; J if [31:20] not all equal or [0]=1; IMM_SEL 110/111 always.
REQ-018 SHALL, on ERROR, output INSTRUCTION=32'h00000013 (NOP) with OUT_VALID=1; the request still completes normally.
REQ-019 SHALL increment ENCODE_COUNT per output handshake, wrapping 16'hFFFF->0.
REQ-020 SHALL increment ERROR_COUNT per output handshake with ERROR=1, saturating at 8'hFF.
REQ-021 SHALL, on simultaneous input accept and output consume with both stages full, shift S1->S2 and load S1 in the same edge.

Reset
REQ-022 SHALL, with RESET=1 at a CLK edge, clear both stage valids, OUT_VALID=0, ERROR=0, INSTRUCTION=0, ENCODE_COUNT=0, ERROR_COUNT=0.
REQ-023 SHALL discard in-flight requests on reset mid-operation; IN_VALID during the reset edge is not accepted.
REQ-024 SHALL drive IN_READY=1 in the first cycle after reset deasserts.

Verification
REQ-025 I-type IMM_SEL=000, OPCODE=0010011, RD=1, RS1=2, FUNCT3=0, IMMEDIATE=1871 -> INSTRUCTION=32'h74F10093, ERROR=0, 2 edges after accept.
REQ-026 S-type IMM_SEL=001, OPCODE=0100011, RS1=2, RS2=1, FUNCT3=010, IMMEDIATE=60 -> 32'h02112E23; B-type IMM_SEL=010, OPCODE=1100011, RS1=1, RS2=2, FUNCT3=0, IMMEDIATE=1200 -> 32'h4A208863.
REQ-027 B-type IMMEDIATE=1201; then IMM_SEL=111 -> both ERROR=1, INSTRUCTION=32'h00000013, ERROR_COUNT=2, ENCODE_COUNT=2.
REQ-028 Back-to-back 3 requests, OUT_READY=0 for 3 cycles then 1 -> IN_READY=0 once both stages full, outputs held stable, all 3 results emerge in order, ENCODE_COUNT=3.
REQ-029 RESET=1 one cycle with 2 requests in flight -> OUT_VALID=0, counters 0 next cycle, no stale result later emitted.
